// File: rtl/sfx_request_encoder_pkg.sv
// Shared audio definitions: SFX code width, encoder FSM states and default
// timing constants. The APU imports this package to decode the same codes.
package sfx_request_encoder_pkg;

  localparam int SFX_CODE_W  = 3;
  localparam int SFX_EVENT_W = 8;

  localparam int SFX_FIFO_DEPTH_DEF = 4;
  localparam int SFX_MIN_GAP_DEF    = 2;
  localparam int SFX_TIMEOUT_DEF    = 8;

  typedef logic [SFX_CODE_W-1:0] sfx_code_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_PRESENT    = 2'd2,
    ST_GAP        = 2'd3
  } sfx_state_e;

  // Index of the highest set flag; bit 7 has the highest priority.
  function automatic sfx_code_t highest_bit(input logic [SFX_EVENT_W-1:0] flags);
    sfx_code_t idx;
    idx = '0;
    for (int i = 0; i < SFX_EVENT_W; i++) begin
      if (flags[i]) idx = SFX_CODE_W'(i);
    end
    return idx;
  endfunction

  // Counter width able to hold 0..max_value, never narrower than 1 bit.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sfx_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and an
// occupancy count kept separately from the wrapping pointers.
module sfx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array has no reset; the count and pointers alone decide
  // which entries are valid, so clearing storage would only add reset fanout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sfx_request_encoder.sv
// Turns level game-event flags into prioritised, frame-aligned sound-effect
// requests for the APU, with coalescing, queueing, timeout and drop counting.
// rst_n is an active-high synchronous reset despite its name.
module sfx_request_encoder
  import sfx_request_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH     = SFX_FIFO_DEPTH_DEF,
  parameter int MIN_GAP_FRAMES = SFX_MIN_GAP_DEF,
  parameter int TIMEOUT_FRAMES = SFX_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [SFX_EVENT_W-1:0] event_in,
  input  logic                  effect_ready,
  output logic                  effect_valid,
  output logic [SFX_CODE_W-1:0] effect_code,
  output logic [3:0]            dropped_count
);

  localparam int GW = cnt_width(MIN_GAP_FRAMES);
  localparam int TW = cnt_width(TIMEOUT_FRAMES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Event capture and frame detection
  logic [SFX_EVENT_W-1:0] event_prev;
  logic [SFX_EVENT_W-1:0] pending;
  logic [SFX_EVENT_W-1:0] rise;
  logic [SFX_EVENT_W-1:0] clear_mask;
  logic [SFX_EVENT_W-1:0] coalesce;
  logic                   origin_prev;
  logic                   at_origin;
  logic                   frame_tick;

  // Queue interface
  logic                   push;
  sfx_code_t              push_code;
  logic                   pop_req;
  logic                   fifo_pop;
  sfx_code_t              fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;

  // Request FSM
  sfx_state_e             state;
  sfx_state_e             state_next;
  logic [GW-1:0]          gap_cnt;
  logic [GW-1:0]          gap_next;
  logic [TW-1:0]          timeout_cnt;
  logic [TW-1:0]          timeout_next;
  sfx_code_t              code_next;
  logic                   timeout_drop;

  // Drop accounting
  logic [3:0]             drop_inc;
  logic [4:0]             drop_sum;
  logic [3:0]             dropped_next;

  assign at_origin  = (x == '0) && (y == '0);
  assign frame_tick = at_origin && !origin_prev;
  assign rise       = event_in & ~event_prev;

  // The highest pending flag is queued whenever there is room; a fresh edge on
  // the same bit in that cycle re-arms it rather than being counted as lost.
  assign push       = !fifo_full && (pending != '0);
  assign push_code  = highest_bit(pending);
  assign clear_mask = push ? (SFX_EVENT_W'(1) << push_code) : '0;
  assign coalesce   = rise & pending & ~clear_mask;

  assign fifo_pop     = pop_req && !fifo_empty;
  assign effect_valid = (state == ST_PRESENT);

  // Every lost event counts once: each coalesced edge plus a timed-out request.
  assign drop_inc     = 4'($countones(coalesce)) + {3'b000, timeout_drop};
  assign drop_sum     = {1'b0, dropped_count} + {1'b0, drop_inc};
  assign dropped_next = (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];

  sfx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SFX_CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (push),
    .push_data (push_code),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Edge/frame history and the pending flag set.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      event_prev  <= '0;
      origin_prev <= 1'b0;
      pending     <= '0;
    end else begin
      event_prev  <= event_in;
      origin_prev <= at_origin;
      pending     <= (pending & ~clear_mask) | rise;
    end
  end

  // FSM state, presented code, frame counters and drop counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      timeout_cnt   <= '0;
      effect_code   <= '0;
      dropped_count <= '0;
    end else begin
      state         <= state_next;
      gap_cnt       <= gap_next;
      timeout_cnt   <= timeout_next;
      effect_code   <= code_next;
      dropped_count <= dropped_next;
    end
  end

  // Next-state logic: present on a frame tick, retire on accept or timeout.
  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    gap_next     = gap_cnt;
    timeout_next = timeout_cnt;
    code_next    = effect_code;
    pop_req      = 1'b0;
    timeout_drop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) state_next = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (frame_tick) begin
          code_next    = fifo_head;
          timeout_next = '0;
          state_next   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Acceptance is checked first so it beats a coincident final timeout.
        if (effect_ready) begin
          pop_req    = 1'b1;
          gap_next   = GW'(MIN_GAP_FRAMES);
          state_next = (MIN_GAP_FRAMES == 0) ? ST_IDLE : ST_GAP;
        end else if (frame_tick) begin
          if (timeout_cnt == TW'(TIMEOUT_FRAMES - 1)) begin
            pop_req      = 1'b1;
            timeout_drop = 1'b1;
            gap_next     = GW'(MIN_GAP_FRAMES);
            state_next   = (MIN_GAP_FRAMES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            timeout_next = timeout_cnt + TW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_next = ST_IDLE;
        end else if (frame_tick) begin
          gap_next = gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
